alu_issue_unit: RTL
===================

# alu_issue_unit

Sequencer sitting directly upstream of the 4-bit decode-and-execute ALU: accepts 12-bit instructions over a valid/ready handshake, holds a 4-entry × 4-bit register file, drives the ALU's `rs`/`rt`/`sel` inputs from registered operands, and writes the combinational ALU result back into the register file. It also supports load-immediate, keeps a last-result register for the 7-segment display stage, and maintains a retired-instruction counter.

## Interface
- `NREG`, 4: register-file depth; fixed, 2-bit addresses.
- `W`, 4: datapath width; matches the ALU.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr_ready`  out  1  unit can accept; transfer when `instr_valid && instr_ready` at a rising edge.
- `instr`  in  12  [11] li, [10:8] op, [7:6] dst, [5:4] src_s, [3:2] src_t, [1:0] reserved (ignored); for li, imm = [3:0].
- `alu_rs`  out  4  registered operand A to the ALU.
- `alu_rt`  out  4  registered operand B to the ALU.
- `alu_sel`  out  3  registered ALU op select.
- `alu_rd`  in  4  combinational ALU result.
- `done`  out  1  one-cycle pulse, the cycle after a writeback edge.
- `last_rd`  out  4  value most recently written to the register file.
- `retire_cnt`  out  8  count of completed instructions, wraps 255 -> 0.
- `dbg_addr`  in  2  debug read address.
- `dbg_data`  out  4  combinational read of `reg[dbg_addr]`.

## Operation
- States: IDLE, EXEC. Reset -> IDLE.
- `instr_ready` = 1 exactly in IDLE (decoded from state, no combinational path from `instr_valid`).
- IDLE, accept, li=0: latch `alu_rs <= reg[src_s]`, `alu_rt <= reg[src_t]`, `alu_sel <= op`, `dst_q <= dst`; go EXEC.
- IDLE, accept, li=1: `reg[dst] <= imm`, `last_rd <= imm`, `retire_cnt++`, `done` pulses next cycle; stay IDLE. `alu_*` unchanged.
- IDLE, no accept: hold everything.
- EXEC: `alu_*` held stable for the whole cycle; at the next edge `reg[dst_q] <= alu_rd`, `last_rd <= alu_rd`, `retire_cnt++`, go IDLE. `instr_valid` ignored in EXEC.
- Operands are read in IDLE from the register file as it stands before the accepting edge; back-to-back dependent instructions need no forwarding since each writeback completes before the next accept.
- src_s == src_t == dst legal; sources read old value, destination gets result.
- ALU op encoding (owned by the ALU, stated for test values): 0 SUB rs-rt, 1 ADD rs+rt, 2 OR, 3 AND, 4 rt arithmetic right shift by 1, 5 rs rotate left by 1, 6 rs<rt unsigned -> 1/0, 7 rs==rt -> 1/0. All arithmetic mod 16; no carry/overflow output.
- `retire_cnt` counts li and ALU instructions equally; 8-bit, silent wrap.
- `dbg_data` has no effect on state; reads during a writeback edge see the old value until after the edge.

## Timing
- Reset (async assert, sync-safe release): state IDLE, reg[0..3] = 0, `alu_rs` = `alu_rt` = 0, `alu_sel` = 0, `dst_q` = 0, `done` = 0, `last_rd` = 0, `retire_cnt` = 0, `instr_ready` = 1.
- ALU instruction: accept edge N; `alu_*` valid from N to N+1; writeback at edge N+1; `done` high in cycle N+1 to N+2; `instr_ready` low in cycle N to N+1, high again from N+1.
- Li: accept edge N, register written at N, `done` high from N to N+1, `instr_ready` stays high.
- Throughput: one ALU instruction per 2 cycles, one li per cycle.
- `rst_n` asserted in EXEC: instruction aborted, no writeback, no `done`, counter not incremented.
- `instr_valid` held high continuously: next instruction accepted on first IDLE edge; an instruction held during EXEC is accepted, not dropped or doubled.

## Test plan
- Reset: assert `rst_n`=0 mid-sim -> all outputs at reset values immediately (no clock), `dbg_data`=0 for all addresses.
- Li + ADD: li r0=5, li r1=3, ADD r2=r0,r1 -> `alu_rs`=5, `alu_rt`=3, `alu_sel`=1 during EXEC; r2=8, `last_rd`=8, `retire_cnt`=3.
- SUB wrap and compare: SUB r3=r1,r0 -> r3=4'hE; LT r0=r1,r3 (3<14) -> r0=1; EQ r1=r1,r1 -> r1=1.
- Handshake: `instr_valid` held high with 4 ALU instructions -> `instr_ready` toggles 1,0,1,0; exactly 4 `done` pulses, 8 cycles total.
- Abort: reset asserted during EXEC of ADD r2 -> r2 stays 0, `done` never pulses, `retire_cnt`=0.
- Counter wrap: 256 li instructions -> `retire_cnt` returns to 0, `last_rd` equals final imm.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue/writeback sequencer in front of the 4-bit ALU: it decodes instructions, registers
// the ALU operands, writes results back, and tracks the last result and the retire count.
module alu_issue_unit #(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [11:0]  instr,
  output logic [W-1:0] alu_rs,
  output logic [W-1:0] alu_rt,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_rd,
  output logic         done,
  output logic [W-1:0] last_rd,
  output logic [7:0]   retire_cnt,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t       state, state_next;
  logic [W-1:0] regs [NREG];
  logic [1:0]   dst_q;

  logic         is_li;
  logic [2:0]   op;
  logic [1:0]   dst, src_s, src_t;
  logic [W-1:0] imm;
  logic         accept;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;

  assign is_li = instr[11];
  assign op    = instr[10:8];
  assign dst   = instr[7:6];
  assign src_s = instr[5:4];
  assign src_t = instr[3:2];
  assign imm   = instr[W-1:0];

  // A load-immediate writes on its accept edge; an ALU op writes one edge later from EXEC.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = dst_q;
    wr_data     = alu_rd;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
        if (instr_valid) begin
          if (is_li) begin
            wr_en   = 1'b1;
            wr_addr = dst;
            wr_data = imm;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        wr_en      = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_rs     <= '0;
      alu_rt     <= '0;
      alu_sel    <= '0;
      dst_q      <= '0;
      done       <= 1'b0;
      last_rd    <= '0;
      retire_cnt <= '0;
    end else begin
      done <= wr_en;
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
        last_rd       <= wr_data;
        retire_cnt    <= retire_cnt + 8'd1;
      end
      if (accept && !is_li) begin
        alu_rs  <= regs[src_s];
        alu_rt  <= regs[src_t];
        alu_sel <= op;
        dst_q   <= dst;
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule
